// File: rtl/syscall_pkg.sv
// Shared opcode, stream tag and FSM state definitions for the system-call engine.
package syscall_pkg;

   typedef enum logic [2:0] {
      OP_HALT    = 3'd0,
      OP_STORE   = 3'd1,
      OP_LOAD    = 3'd2,
      OP_PUTDEC  = 3'd3,
      OP_PUTCHAR = 3'd4,
      OP_PUTSTR  = 3'd5
   } op_e;

   localparam int unsigned OP_LAST = 5;

   localparam logic TAG_CHAR = 1'b0;
   localparam logic TAG_DEC  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_WAIT,
      S_EMIT,
      S_STR_RD,
      S_STR_CHK,
      S_STR_EMIT,
      S_HALT
   } state_e;

endpackage

// File: rtl/syscall_ram.sv
// Single-port word RAM, one-cycle registered read, write-first on a same-cycle write.
module syscall_ram #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 2**ADDR_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
         rdata_q       <= wdata_i;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/syscall_unit.sv
// System-call engine: handshaked request in, private RAM, back-pressured char/decimal stream out.
module syscall_unit
   import syscall_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MEM_DEPTH = 2**ADDR_W,
   parameter int MAX_STR   = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [DATA_W-1:0] req_op_i,
   input  logic [DATA_W-1:0] req_arg0_i,
   input  logic [DATA_W-1:0] req_arg1_i,
   output logic              load_valid_o,
   output logic [DATA_W-1:0] load_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_tag_o,
   output logic              op_done_o,
   output logic              op_err_o,
   output logic              str_trunc_o,
   output logic              halted_o
);

   localparam int CNT_W = $clog2(MAX_STR + 1);

   state_e            state_q;
   logic              req_ready_q;
   logic              load_valid_q;
   logic [DATA_W-1:0] load_data_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_tag_q;
   logic              op_done_q;
   logic              op_err_q;
   logic              str_trunc_q;
   logic              halted_q;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   logic              op_legal;
   op_e               op;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [DATA_W-1:0] a);
      return ADDR_W'(32'(a) % 32'(MEM_DEPTH));
   endfunction

   assign accept   = req_valid_i & req_ready_q;
   assign op_legal = (req_op_i <= DATA_W'(OP_LAST));
   assign op       = op_e'(req_op_i[2:0]);

   // The RAM port belongs to the request path in IDLE and to the string pointer otherwise.
   assign ram_we   = accept & op_legal & (op == OP_STORE) & ~rst_i;
   assign ram_addr = (state_q == S_IDLE) ? wrap_addr(req_arg0_i) : ptr_q;

   assign ptr_d = (32'(ptr_q) == MEM_DEPTH - 1) ? '0 : ptr_q + 1'b1;
   assign cnt_d = cnt_q + 1'b1;

   syscall_ram #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MEM_DEPTH(MEM_DEPTH)
   ) u_ram (
      .clk_i  (clk_i),
      .we_i   (ram_we),
      .addr_i (ram_addr),
      .wdata_i(req_arg1_i),
      .rdata_o(ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_tag_q    <= TAG_CHAR;
         op_done_q    <= 1'b0;
         op_err_q     <= 1'b0;
         str_trunc_q  <= 1'b0;
         halted_q     <= 1'b0;
         ptr_q        <= '0;
         cnt_q        <= '0;
      end else begin
         load_valid_q <= 1'b0;
         op_done_q    <= 1'b0;
         op_err_q     <= 1'b0;
         str_trunc_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (!op_legal) begin
                     op_err_q <= 1'b1;
                  end else begin
                     unique case (op)
                        OP_HALT: begin
                           state_q     <= S_HALT;
                           halted_q    <= 1'b1;
                           req_ready_q <= 1'b0;
                           op_done_q   <= 1'b1;
                        end
                        OP_STORE: begin
                           op_done_q <= 1'b1;
                        end
                        OP_LOAD: begin
                           state_q     <= S_LD_WAIT;
                           req_ready_q <= 1'b0;
                        end
                        OP_PUTDEC, OP_PUTCHAR: begin
                           state_q     <= S_EMIT;
                           req_ready_q <= 1'b0;
                           out_valid_q <= 1'b1;
                           out_data_q  <= req_arg0_i;
                           out_tag_q   <= (op == OP_PUTDEC) ? TAG_DEC : TAG_CHAR;
                        end
                        OP_PUTSTR: begin
                           state_q     <= S_STR_RD;
                           req_ready_q <= 1'b0;
                           ptr_q       <= wrap_addr(req_arg0_i);
                           cnt_q       <= '0;
                        end
                        default: begin
                           op_err_q <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_LD_WAIT: begin
               load_data_q  <= ram_rdata;
               load_valid_q <= 1'b1;
               op_done_q    <= 1'b1;
               state_q      <= S_IDLE;
               req_ready_q  <= 1'b1;
            end
            S_EMIT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  op_done_q   <= 1'b1;
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end
            end
            S_STR_RD: begin
               state_q <= S_STR_CHK;
            end
            S_STR_CHK: begin
               // The terminator wins over truncation: a string of exactly MAX_STR chars is not truncated.
               if (ram_rdata == '0) begin
                  op_done_q   <= 1'b1;
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else if (cnt_q == CNT_W'(MAX_STR)) begin
                  str_trunc_q <= 1'b1;
                  op_done_q   <= 1'b1;
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= ram_rdata;
                  out_tag_q   <= TAG_CHAR;
                  state_q     <= S_STR_EMIT;
               end
            end
            S_STR_EMIT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  ptr_q       <= ptr_d;
                  cnt_q       <= cnt_d;
                  state_q     <= S_STR_RD;
               end
            end
            S_HALT: begin
               req_ready_q <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign load_valid_o = load_valid_q;
   assign load_data_o  = load_data_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_tag_o    = out_tag_q;
   assign op_done_o    = op_done_q;
   assign op_err_o     = op_err_q;
   assign str_trunc_o  = str_trunc_q;
   assign halted_o     = halted_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: RAM store/load, string/char/decimal streaming, truncation, halt, reset.
module tb_syscall_unit;
   import syscall_pkg::*;

   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [DW-1:0] req_op = '0;
   logic [DW-1:0] req_arg0 = '0;
   logic [DW-1:0] req_arg1 = '0;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_tag;
   logic          op_done;
   logic          op_err;
   logic          str_trunc;
   logic          halted;

   int n_pass = 0;
   int n_tot  = 0;

   logic [DW-1:0] got_q[$];
   logic          done_seen;
   logic          trunc_seen;

   always #5 clk = ~clk;

   syscall_unit #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .MEM_DEPTH(2**AW),
      .MAX_STR  (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_arg0_i  (req_arg0),
      .req_arg1_i  (req_arg1),
      .load_valid_o(load_valid),
      .load_data_o (load_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_tag_o   (out_tag),
      .op_done_o   (op_done),
      .op_err_o    (op_err),
      .str_trunc_o (str_trunc),
      .halted_o    (halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send(input logic [DW-1:0] op, input logic [DW-1:0] a0, input logic [DW-1:0] a1);
      int k;
      k = 0;
      while (!req_ready && k < 50) begin
         tick();
         k++;
      end
      check("ready_wait", 32'(req_ready), 32'd1);
      req_op    = op;
      req_arg0  = a0;
      req_arg1  = a1;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_ov();
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      check("out_valid_wait", 32'(out_valid), 32'd1);
   endtask

   // Drains a PUTSTR with the sink always ready, recording every accepted word.
   task automatic collect();
      got_q.delete();
      done_seen  = 1'b0;
      trunc_seen = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 200 && !done_seen; i++) begin
         if (out_valid) got_q.push_back(out_data);
         tick();
         if (op_done) begin
            done_seen  = 1'b1;
            trunc_seen = str_trunc;
         end
      end
      out_ready = 1'b0;
      check("str_done", 32'(done_seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_op_done", 32'(op_done), 32'd0);
      check("rst_load_valid", 32'(load_valid), 32'd0);
      check("rst_load_data", 32'(load_data), 32'd0);
      rst = 1'b0;
      tick();

      // STORE then back-to-back LOAD of the same word
      req_op = 16'(OP_STORE); req_arg0 = 16'h0010; req_arg1 = 16'h0041; req_valid = 1'b1;
      tick();
      check("store_done", 32'(op_done), 32'd1);
      check("store_ready", 32'(req_ready), 32'd1);
      req_op = 16'(OP_LOAD); req_arg0 = 16'h0010; req_arg1 = 16'h0000;
      tick();
      req_valid = 1'b0;
      check("load_busy", 32'(req_ready), 32'd0);
      check("load_early", 32'(load_valid), 32'd0);
      tick();
      check("load_valid", 32'(load_valid), 32'd1);
      check("load_data", 32'(load_data), 32'h0041);
      check("load_done", 32'(op_done), 32'd1);
      tick();
      check("load_pulse", 32'(load_valid), 32'd0);
      check("load_hold", 32'(load_data), 32'h0041);
      check("load_ready", 32'(req_ready), 32'd1);

      // String images: "Hi" at 0x20, "A"/"B" across the wrap, 6 chars at 0x30
      send(16'(OP_STORE), 16'h0020, 16'h0048);
      send(16'(OP_STORE), 16'h0021, 16'h0069);
      send(16'(OP_STORE), 16'h0022, 16'h0000);
      send(16'(OP_STORE), 16'hFFFF, 16'h0041);
      send(16'(OP_STORE), 16'h0000, 16'h0042);
      send(16'(OP_STORE), 16'h0001, 16'h0000);
      for (int i = 0; i < 6; i++) send(16'(OP_STORE), 16'(16'h0030 + i), 16'(16'h0061 + i));
      send(16'(OP_STORE), 16'h0036, 16'h0000);

      // PUTSTR "Hi" with sink stalled three cycles on 'H'
      send(16'(OP_PUTSTR), 16'h0020, 16'h0000);
      check("str_busy", 32'(req_ready), 32'd0);
      wait_ov();
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'h0048);
         check("hold_tag", 32'(out_tag), 32'(TAG_CHAR));
         tick();
      end
      collect();
      check("hi_len", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         check("hi_c0", 32'(got_q[0]), 32'h0048);
         check("hi_c1", 32'(got_q[1]), 32'h0069);
      end
      check("hi_trunc", 32'(trunc_seen), 32'd0);
      check("hi_idle_valid", 32'(out_valid), 32'd0);

      // PUTSTR starting at the top address wraps to 0
      send(16'(OP_PUTSTR), 16'hFFFF, 16'h0000);
      collect();
      check("wrap_len", 32'(got_q.size()), 32'd2);
      if (got_q.size() == 2) begin
         check("wrap_c0", 32'(got_q[0]), 32'h0041);
         check("wrap_c1", 32'(got_q[1]), 32'h0042);
      end
      check("wrap_trunc", 32'(trunc_seen), 32'd0);

      // Six-char string with MAX_STR=4
      send(16'(OP_PUTSTR), 16'h0030, 16'h0000);
      collect();
      check("trunc_len", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         check("trunc_c0", 32'(got_q[0]), 32'h0061);
         check("trunc_c3", 32'(got_q[3]), 32'h0064);
      end
      check("trunc_flag", 32'(trunc_seen), 32'd1);
      tick();
      check("trunc_pulse", 32'(str_trunc), 32'd0);

      // PUTDEC with back-pressure
      send(16'(OP_PUTDEC), 16'h04D2, 16'h0000);
      check("dec_valid", 32'(out_valid), 32'd1);
      check("dec_tag", 32'(out_tag), 32'(TAG_DEC));
      check("dec_data", 32'(out_data), 32'h04D2);
      check("dec_busy", 32'(req_ready), 32'd0);
      tick();
      check("dec_stall", 32'(out_data), 32'h04D2);
      check("dec_nodone", 32'(op_done), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("dec_done", 32'(op_done), 32'd1);
      check("dec_drop", 32'(out_valid), 32'd0);
      check("dec_ready", 32'(req_ready), 32'd1);

      // PUTCHAR
      send(16'(OP_PUTCHAR), 16'h007A, 16'h0000);
      check("chr_tag", 32'(out_tag), 32'(TAG_CHAR));
      check("chr_data", 32'(out_data), 32'h007A);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("chr_done", 32'(op_done), 32'd1);

      // Illegal opcode: error pulse only, RAM untouched
      send(16'd7, 16'h0010, 16'hBEEF);
      check("ill_err", 32'(op_err), 32'd1);
      check("ill_done", 32'(op_done), 32'd0);
      check("ill_valid", 32'(out_valid), 32'd0);
      check("ill_ready", 32'(req_ready), 32'd1);
      tick();
      check("ill_pulse", 32'(op_err), 32'd0);
      send(16'(OP_LOAD), 16'h0010, 16'h0000);
      tick();
      check("ill_ram", 32'(load_data), 32'h0041);

      // Reset while a string char is being held
      send(16'(OP_PUTSTR), 16'h0020, 16'h0000);
      wait_ov();
      rst = 1'b1;
      tick();
      check("rstmid_valid", 32'(out_valid), 32'd0);
      check("rstmid_ready", 32'(req_ready), 32'd1);
      rst = 1'b0;
      tick();

      // HALT is sticky until reset
      send(16'(OP_HALT), 16'h0000, 16'h0000);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_ready", 32'(req_ready), 32'd0);
      check("halt_done", 32'(op_done), 32'd1);
      req_op = 16'(OP_PUTCHAR); req_arg0 = 16'h0055; req_valid = 1'b1;
      tick();
      tick();
      req_valid = 1'b0;
      check("halt_ignored", 32'(out_valid), 32'd0);
      check("halt_nodone", 32'(op_done), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("halt_rst_flag", 32'(halted), 32'd0);
      check("halt_rst_ready", 32'(req_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
